// File: rtl/serial_deserializer_pkg.sv
// Shared types and helpers for the serial deserializer slice.
// Optional all_ones output is enabled with SERDES_ALL_ONES_EN.
package serial_deserializer_pkg;

    localparam int unsigned N_DEFAULT = 8;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_e;

    // Bit-counter width for an N-bit word (never below one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial-in / parallel-out handshake bundle for serial_deserializer.
// all_ones is present only when SERDES_ALL_ONES_EN is defined.
interface serial_deserializer_if
    import serial_deserializer_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
);
    logic         ser_in;
    logic         ser_valid;
    logic         ser_ready;
    logic [N-1:0] par_out;
    logic         par_valid;
    logic         par_ready;
`ifdef SERDES_ALL_ONES_EN
    logic         all_ones;
`endif

    // Environment side: drives serial bits, consumes words.
    modport master (
        output ser_in, ser_valid, par_ready,
`ifdef SERDES_ALL_ONES_EN
        input  all_ones,
`endif
        input  ser_ready, par_out, par_valid
    );

    // Deserializer side.
    modport slave (
        input  ser_in, ser_valid, par_ready,
`ifdef SERDES_ALL_ONES_EN
        output all_ones,
`endif
        output ser_ready, par_out, par_valid
    );
endinterface

// File: rtl/and_reduce.sv
// N-input AND reduction; used for the optional all_ones flag.
module and_reduce #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] data,
    output logic         y
);
    assign y = &data;
endmodule

// File: rtl/serial_deserializer_bit_counter.sv
// Modulo-N bit counter with enable, synchronous clear and terminal-count flag.
module deser_bit_counter
    import serial_deserializer_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc_c
);
    localparam int unsigned CW = cnt_width(N);

    logic [CW-1:0] count;
    logic          at_last_c;

    assign at_last_c = (count == CW'(N - 1));
    assign tc_c      = en && at_last_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_last_c ? '0 : count + CW'(1);
        end
    end
endmodule

// File: rtl/serial_deserializer.sv
// Bit-serial to N-bit parallel converter, LSB first, valid/ready on both sides.
// Define SERDES_ALL_ONES_EN to add the all_ones flag on par_out.
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    serial_deserializer_if.slave  bus
);
    state_e       state, state_next;
    logic [N-2:0] sh;
    logic [N-1:0] shift_c;
    logic [N-1:0] par_q;
    logic         valid_q;
    logic         accept_c;
    logic         tc_c;

    // sh holds the previous N-1 bits; the newest bit lands on top.
    assign shift_c = {bus.ser_in, sh};

    deser_bit_counter #(.N(N)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (accept_c),
        .tc_c  (tc_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        if (clr) begin
            state_next = COLLECT;
        end else begin
            case (state)
                COLLECT: begin
                    accept_c = bus.ser_valid;
                    if (bus.ser_valid && tc_c) state_next = FULL;
                end
                FULL: begin
                    if (bus.par_ready) state_next = COLLECT;
                end
                default: state_next = COLLECT;
            endcase
        end
    end

    // Shift register and output word; par_out keeps its value across clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh      <= '0;
            par_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state_next == FULL);
            if (clr) begin
                sh <= '0;
            end else if (accept_c) begin
                sh <= shift_c[N-1:1];
                if (tc_c) par_q <= shift_c;
            end
        end
    end

    assign bus.ser_ready = (state == COLLECT);
    assign bus.par_out   = par_q;
    assign bus.par_valid = valid_q;

`ifdef SERDES_ALL_ONES_EN
    and_reduce #(.N(N)) u_all_ones (
        .data (par_q),
        .y    (bus.all_ones)
    );
`endif
endmodule

// File: tb/tb_serial_deserializer.sv
// Directed self-checking bench for serial_deserializer with N=4.
module tb_serial_deserializer;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    int   n_assert = 0;
    int   n_fail   = 0;

    serial_deserializer_if #(.N(N)) bus ();

    serial_deserializer #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge; inputs then change 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        bus.ser_in    = b;
        bus.ser_valid = 1'b1;
        step();
        bus.ser_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.ser_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.ser_in    = 1'b0;
        bus.ser_valid = 1'b0;
        bus.par_ready = 1'b0;
        #12;
        chk("rst_par_valid", 32'(bus.par_valid), 32'd0);
        chk("rst_par_out",   32'(bus.par_out),   32'd0);
        chk("rst_ser_ready", 32'(bus.ser_ready), 32'd1);
`ifdef SERDES_ALL_ONES_EN
        chk("rst_all_ones",  32'(bus.all_ones),  32'd0);
`endif
        rst_n = 1'b1;
        step();

        // Basic word 1,0,1,1 -> 4'b1101
        send(1'b1); send(1'b0); send(1'b1);
        chk("w1_not_yet", 32'(bus.par_valid), 32'd0);
        send(1'b1);
        chk("w1_valid",  32'(bus.par_valid), 32'd1);
        chk("w1_data",   32'(bus.par_out),   32'hD);
        chk("w1_ready0", 32'(bus.ser_ready), 32'd0);

        // Back-pressure: bits offered while FULL must be ignored
        bus.ser_valid = 1'b1;
        bus.ser_in    = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("hold_data",  32'(bus.par_out),   32'hD);
        chk("hold_valid", 32'(bus.par_valid), 32'd1);
        bus.par_ready = 1'b1;
        step();
        bus.par_ready = 1'b0;
        bus.ser_valid = 1'b0;
        chk("take_valid", 32'(bus.par_valid), 32'd0);
        chk("take_ready", 32'(bus.ser_ready), 32'd1);
        send(1'b0); send(1'b1); send(1'b0);
        chk("w2_not_yet", 32'(bus.par_valid), 32'd0);
        send(1'b0);
        chk("w2_valid", 32'(bus.par_valid), 32'd1);
        chk("w2_data",  32'(bus.par_out),   32'h2);
        bus.par_ready = 1'b1;
        step();
        bus.par_ready = 1'b0;

        // Stalls between bits: 0,1, 3 idle, 1,0 -> 4'b0110
        send(1'b0); send(1'b1);
        bus.ser_in = 1'b1;
        idle(3);
        chk("stall_valid", 32'(bus.par_valid), 32'd0);
        send(1'b1);
        chk("stall_not_yet", 32'(bus.par_valid), 32'd0);
        send(1'b0);
        chk("stall_valid2", 32'(bus.par_valid), 32'd1);
        chk("stall_data",   32'(bus.par_out),   32'h6);
        bus.par_ready = 1'b1;
        step();
        bus.par_ready = 1'b0;

        // Clear after two bits, then 1,1,1,1 -> 4'b1111
        send(1'b0); send(1'b0);
        clr           = 1'b1;
        bus.ser_valid = 1'b1;
        bus.ser_in    = 1'b1;
        step();
        clr           = 1'b0;
        bus.ser_valid = 1'b0;
        send(1'b1); send(1'b1); send(1'b1);
        chk("clr_not_yet", 32'(bus.par_valid), 32'd0);
        send(1'b1);
        chk("clr_valid", 32'(bus.par_valid), 32'd1);
        chk("clr_data",  32'(bus.par_out),   32'hF);
`ifdef SERDES_ALL_ONES_EN
        chk("clr_all_ones", 32'(bus.all_ones), 32'd1);
`endif

        // Asynchronous reset between edges while FULL
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.par_valid), 32'd0);
        chk("arst_data",  32'(bus.par_out),   32'd0);
        chk("arst_ready", 32'(bus.ser_ready), 32'd1);
`ifdef SERDES_ALL_ONES_EN
        chk("arst_all_ones", 32'(bus.all_ones), 32'd0);
`endif
        #1;
        rst_n = 1'b1;
        send(1'b1); send(1'b1); send(1'b0); send(1'b1);
        chk("fresh_valid", 32'(bus.par_valid), 32'd1);
        chk("fresh_data",  32'(bus.par_out),   32'hB);
`ifdef SERDES_ALL_ONES_EN
        chk("fresh_all_ones", 32'(bus.all_ones), 32'd0);
`endif

        // clr beats par_ready and ser_valid in the same cycle
        clr           = 1'b1;
        bus.par_ready = 1'b1;
        bus.ser_valid = 1'b1;
        bus.ser_in    = 1'b1;
        step();
        clr           = 1'b0;
        bus.par_ready = 1'b0;
        bus.ser_valid = 1'b0;
        chk("prio_valid", 32'(bus.par_valid), 32'd0);
        chk("prio_data",  32'(bus.par_out),   32'hB);
        chk("prio_ready", 32'(bus.ser_ready), 32'd1);
        send(1'b0); send(1'b0); send(1'b0);
        chk("prio_not_yet", 32'(bus.par_valid), 32'd0);
        send(1'b1);
        chk("prio_w_valid", 32'(bus.par_valid), 32'd1);
        chk("prio_w_data",  32'(bus.par_out),   32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
